radiant_readout_sequencer: RTL and testbench

- Responder to the trigger governor. Accepts its trigger pulse and trigger-info word, emits one event header, runs NUM_SEQ LAB4 readout sequences through a req/ack handshake, then pulses readout-done.
- Reports run state and buffer-full status back to the governor, so the governor can clear its busy flag and apply flow control.
- Tracks buffered-event occupancy, decremented by DMA completions.

---
 rtl/radiant_readout_pkg.sv | 23 ++
 rtl/radiant_event_occupancy.sv | 48 ++++
 rtl/radiant_readout_sequencer.sv | 151 +++++++++++++++
 tb/tb_radiant_readout_sequencer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/radiant_readout_pkg.sv
// Shared types and header layout for the LAB4 readout sequencer.
// Header word: {timestamp[31:0], event_num[15:0], trig_info[15:0]}.
package radiant_readout_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHeader,
    StSeq,
    StDone
  } seq_state_e;

  localparam int unsigned HDR_WIDTH      = 64;
  localparam int unsigned HDR_TRIG_LSB   = 0;
  localparam int unsigned HDR_TRIG_W     = 16;
  localparam int unsigned HDR_EVNUM_LSB  = 16;
  localparam int unsigned HDR_EVNUM_W    = 16;
  localparam int unsigned HDR_TS_LSB     = 32;
  localparam int unsigned HDR_TS_W       = 32;

  localparam int unsigned OCC_WIDTH      = 4;
  localparam int unsigned DROP_WIDTH     = 16;

endpackage

// File: rtl/radiant_event_occupancy.sv
// Saturating up/down count of buffered events with a registered full flag.
// The full flag lags the count by one cycle.
module radiant_event_occupancy
  import radiant_readout_pkg::*;
#(
  parameter int unsigned MAX_EVENTS = 4
) (
  input  logic                 sys_clk_i,
  input  logic                 sys_rst_n_i,
  input  logic                 inc_i,
  input  logic                 dec_i,
  output logic [OCC_WIDTH-1:0] occupancy_o,
  output logic                 full_o
);

  localparam logic [OCC_WIDTH-1:0] OccMax     = '1;
  localparam logic [OCC_WIDTH-1:0] FullThresh = OCC_WIDTH'(MAX_EVENTS);

  logic [OCC_WIDTH-1:0] occ_d, occ_q;
  logic                 full_q;

  always_comb begin
    occ_d = occ_q;
    if (inc_i && !dec_i) begin
      if (occ_q != OccMax) begin
        occ_d = occ_q + 1'b1;
      end
    end else if (dec_i && !inc_i) begin
      if (occ_q != '0) begin
        occ_d = occ_q - 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      occ_q  <= '0;
      full_q <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      full_q <= (occ_q >= FullThresh);
    end
  end

  assign occupancy_o = occ_q;
  assign full_o      = full_q;

endmodule

// File: rtl/radiant_readout_sequencer.sv
// Trigger responder: emits an event header, runs NUM_SEQ LAB4 readout sequences, pulses done.
// RADIANT_SEQ_TIMESTAMP_EN adds a free-running 32-bit timestamp to header bits [63:32].
module radiant_readout_sequencer
  import radiant_readout_pkg::*;
#(
  parameter int unsigned NUM_SEQ    = 1,
  parameter int unsigned MAX_EVENTS = 4
) (
  input  logic                  sys_clk_i,
  input  logic                  sys_rst_n_i,
  input  logic                  run_i,
  input  logic                  trig_i,
  input  logic [15:0]           trig_info_i,
  output logic                  readout_running_o,
  output logic                  readout_done_o,
  output logic                  readout_full_o,
  output logic                  seq_req_o,
  input  logic                  seq_ack_i,
  output logic                  header_valid_o,
  output logic [HDR_WIDTH-1:0]  header_data_o,
  input  logic                  header_ready_i,
  input  logic                  dma_done_i,
  output logic [DROP_WIDTH-1:0] dropped_count_o,
  output logic                  busy_o
);

  localparam logic [1:0] SeqLast = 2'(NUM_SEQ - 1);

  seq_state_e            state_d, state_q;
  logic [1:0]            seq_cnt_d, seq_cnt_q;
  logic [15:0]           event_num_d, event_num_q;
  logic [HDR_WIDTH-1:0]  header_d, header_q;
  logic [DROP_WIDTH-1:0] dropped_d, dropped_q;
  logic                  running_q;
  logic                  accept, drop, occ_inc, full;
  logic [HDR_TS_W-1:0]   ts_now;
  logic [OCC_WIDTH-1:0]  occupancy;

`ifdef RADIANT_SEQ_TIMESTAMP_EN
  logic [HDR_TS_W-1:0] ts_q;

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
    end
  end

  assign ts_now = ts_q;
`else
  assign ts_now = '0;
`endif

  always_comb begin
    state_d   = state_q;
    seq_cnt_d = seq_cnt_q;
    accept    = 1'b0;
    drop      = 1'b0;
    occ_inc   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trig_i && run_i) begin
          if (!full) begin
            accept  = 1'b1;
            state_d = StHeader;
          end else begin
            drop = 1'b1;
          end
        end
      end
      StHeader: begin
        if (header_ready_i) begin
          state_d   = StSeq;
          seq_cnt_d = '0;
        end
      end
      StSeq: begin
        if (seq_ack_i) begin
          seq_cnt_d = seq_cnt_q + 1'b1;
          if (seq_cnt_q == SeqLast) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        occ_inc = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Triggers arriving mid-event are counted but never disturb the event in flight.
    if (state_q != StIdle && trig_i) begin
      drop = 1'b1;
    end
  end

  always_comb begin
    event_num_d = event_num_q;
    header_d    = header_q;
    if (accept) begin
      event_num_d                                 = event_num_q + 1'b1;
      header_d[HDR_TRIG_LSB  +: HDR_TRIG_W]       = trig_info_i;
      header_d[HDR_EVNUM_LSB +: HDR_EVNUM_W]      = event_num_q;
      header_d[HDR_TS_LSB    +: HDR_TS_W]         = ts_now;
    end
    dropped_d = dropped_q;
    if (drop && (dropped_q != '1)) begin
      dropped_d = dropped_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_q     <= StIdle;
      seq_cnt_q   <= '0;
      event_num_q <= '0;
      header_q    <= '0;
      dropped_q   <= '0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_cnt_q   <= seq_cnt_d;
      event_num_q <= event_num_d;
      header_q    <= header_d;
      dropped_q   <= dropped_d;
      running_q   <= run_i;
    end
  end

  radiant_event_occupancy #(
    .MAX_EVENTS (MAX_EVENTS)
  ) u_occupancy (
    .sys_clk_i   (sys_clk_i),
    .sys_rst_n_i (sys_rst_n_i),
    .inc_i       (occ_inc),
    .dec_i       (dma_done_i),
    .occupancy_o (occupancy),
    .full_o      (full)
  );

  assign readout_running_o = running_q;
  assign readout_done_o    = (state_q == StDone);
  assign readout_full_o    = full;
  assign seq_req_o         = (state_q == StSeq);
  assign header_valid_o    = (state_q == StHeader);
  assign header_data_o     = header_q;
  assign dropped_count_o   = dropped_q;
  assign busy_o            = (state_q != StIdle);

endmodule

// File: tb/tb_radiant_readout_sequencer.sv
// Directed bench for radiant_readout_sequencer with NUM_SEQ=2, MAX_EVENTS=4.
// Inputs change 2ns after the rising edge; outputs are sampled on the falling edge.
module tb_radiant_readout_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        trig = 1'b0;
  logic [15:0] trig_info = '0;
  logic        running, done, full, seq_req, seq_ack = 1'b0;
  logic        hdr_valid, hdr_ready = 1'b0, dma_done = 1'b0, busy;
  logic [63:0] hdr_data;
  logic [15:0] dropped;
  logic [3:0]  occ;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int hdr_cnt = 0;
  int rounds = 0;
  int req_age = 0;
  bit auto_ack = 1'b0;
  logic [63:0] last_hdr = '0;

  radiant_readout_sequencer #(
    .NUM_SEQ    (2),
    .MAX_EVENTS (4)
  ) dut (
    .sys_clk_i         (clk),
    .sys_rst_n_i       (rst_n),
    .run_i             (run),
    .trig_i            (trig),
    .trig_info_i       (trig_info),
    .readout_running_o (running),
    .readout_done_o    (done),
    .readout_full_o    (full),
    .seq_req_o         (seq_req),
    .seq_ack_i         (seq_ack),
    .header_valid_o    (hdr_valid),
    .header_data_o     (hdr_data),
    .header_ready_i    (hdr_ready),
    .dma_done_i        (dma_done),
    .dropped_count_o   (dropped),
    .busy_o            (busy)
  );

  assign occ = dut.u_occupancy.occupancy_o;

  always #5 clk = ~clk;

  // Sequence responder: ack two cycles after req is seen.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (auto_ack && seq_req && !seq_ack) begin
        if (req_age == 1) begin
          seq_ack = 1'b1;
          req_age = 0;
        end else begin
          req_age++;
        end
      end else begin
        seq_ack = 1'b0;
        if (!seq_req) req_age = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (seq_req && seq_ack) rounds++;
      if (hdr_valid && hdr_ready) begin
        last_hdr = hdr_data;
        hdr_cnt++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_trig(input logic [15:0] info);
    @(posedge clk);
    #2;
    trig = 1'b1;
    trig_info = info;
    @(posedge clk);
    #2;
    trig = 1'b0;
  endtask

  task automatic pulse_dma();
    @(posedge clk);
    #2;
    dma_done = 1'b1;
    @(posedge clk);
    #2;
    dma_done = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int start = done_cnt;
    bit seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (done_cnt != start) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: no readout_done pulse within 80 cycles", name);
    end
  endtask

  task automatic wait_req(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (seq_req) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: seq_req never rose within 40 cycles", name);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({running, done, full, seq_req, hdr_valid, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000", {running, done, full, seq_req, hdr_valid, busy});
    end
    checks++;
    if (hdr_data !== 64'h0 || dropped !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: hdr %h dropped %h want 0/0", hdr_data, dropped);
    end
    idle(3);
    rst_n = 1'b1;
    run = 1'b1;
    hdr_ready = 1'b1;
    auto_ack = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    int r0 = rounds;
    pulse_trig(16'h0015);
    wait_done("basic_done");
    idle(3);
    checks++;
    if (hdr_cnt !== 1 || last_hdr !== 64'h0000_0000_0000_0015) begin
      errors++;
      $display("FAIL basic_header: got %h (count %0d) want 0000000000000015 (1)", last_hdr, hdr_cnt);
    end
    checks++;
    if (rounds - r0 !== 2) begin
      errors++;
      $display("FAIL basic_rounds: got %0d want 2", rounds - r0);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL basic_done_count: got %0d want 1", done_cnt);
    end
    checks++;
    if (occ !== 4'd1 || full !== 1'b0) begin
      errors++;
      $display("FAIL basic_occupancy: occ %0d full %b want 1/0", occ, full);
    end
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL basic_running: got %b want 1", running);
    end
  endtask

  task automatic test_run_low();
    int h0 = hdr_cnt;
    run = 1'b0;
    pulse_trig(16'h0077);
    idle(3);
    #3;
    checks++;
    if (hdr_cnt !== h0 || busy !== 1'b0 || dropped !== 16'd0 || running !== 1'b0) begin
      errors++;
      $display("FAIL run_low: hdrs %0d busy %b dropped %0d running %b want %0d/0/0/0",
               hdr_cnt - h0, busy, dropped, running, 0);
    end
    run = 1'b1;
    idle(2);
  endtask

  task automatic test_full();
    int h0;
    pulse_dma();
    idle(3);
    checks++;
    if (occ !== 4'd0) begin
      errors++;
      $display("FAIL full_drain: occ %0d want 0", occ);
    end
    for (int i = 1; i <= 4; i++) begin
      pulse_trig(16'h0100 + 16'(i));
      wait_done("full_fill_done");
      idle(3);
    end
    checks++;
    if (last_hdr[31:0] !== 32'h0004_0104) begin
      errors++;
      $display("FAIL full_last_header: got %h want 00040104", last_hdr[31:0]);
    end
    checks++;
    if (full !== 1'b1 || occ !== 4'd4) begin
      errors++;
      $display("FAIL full_assert: full %b occ %0d want 1/4", full, occ);
    end
    h0 = hdr_cnt;
    pulse_trig(16'h0105);
    idle(3);
    checks++;
    if (dropped !== 16'd1 || hdr_cnt !== h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_drop: dropped %0d hdrs %0d busy %b want 1/0/0", dropped, hdr_cnt - h0, busy);
    end
    pulse_dma();
    @(negedge clk);
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL full_lag: got %b want 1", full);
    end
    @(negedge clk);
    checks++;
    if (full !== 1'b0 || occ !== 4'd3) begin
      errors++;
      $display("FAIL full_release: full %b occ %0d want 0/3", full, occ);
    end
  endtask

  task automatic test_drop_during_seq();
    int h0;
    pulse_dma();
    idle(3);
    h0 = hdr_cnt;
    pulse_trig(16'h00AA);
    wait_req("drop_req");
    pulse_trig(16'h00BB);
    wait_done("drop_done");
    idle(3);
    checks++;
    if (dropped !== 16'd2) begin
      errors++;
      $display("FAIL drop_count: got %0d want 2", dropped);
    end
    checks++;
    if (hdr_cnt - h0 !== 1 || last_hdr[31:0] !== 32'h0005_00AA) begin
      errors++;
      $display("FAIL drop_header: got %h (%0d hdrs) want 000500AA (1)", last_hdr[31:0], hdr_cnt - h0);
    end
  endtask

  task automatic test_done_with_dma();
    bit seen = 1'b0;
    pulse_dma();
    idle(3);
    pulse_trig(16'h00CC);
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    dma_done = 1'b1;
    @(posedge clk);
    #2;
    dma_done = 1'b0;
    idle(3);
    checks++;
    if (!seen || occ !== 4'd2) begin
      errors++;
      $display("FAIL done_dma_occ: seen %b occ %0d want 1/2", seen, occ);
    end
    checks++;
    if (last_hdr[31:0] !== 32'h0006_00CC) begin
      errors++;
      $display("FAIL done_dma_evnum: got %h want 000600CC", last_hdr[31:0]);
    end
  endtask

  task automatic test_header_stall();
    bit seen = 1'b0;
    bit stable = 1'b1;
    bit no_req = 1'b1;
    logic [63:0] held;
    hdr_ready = 1'b0;
    pulse_trig(16'h0033);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (hdr_valid) seen = 1'b1;
    end
    held = hdr_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!hdr_valid || hdr_data !== held) stable = 1'b0;
      if (seq_req) no_req = 1'b0;
    end
    checks++;
    if (!seen || held[31:0] !== 32'h0007_0033) begin
      errors++;
      $display("FAIL stall_header: seen %b data %h want 1/00070033", seen, held[31:0]);
    end
    checks++;
    if (!stable || !no_req) begin
      errors++;
      $display("FAIL stall_hold: stable %b no_req %b want 1/1", stable, no_req);
    end
    @(posedge clk);
    #2;
    hdr_ready = 1'b1;
    wait_done("stall_done");
    idle(3);
    pulse_dma();
    idle(3);
  endtask

  task automatic test_reset_mid();
    int d0;
    pulse_trig(16'h0044);
    wait_req("rst_req");
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (seq_req !== 1'b0 || busy !== 1'b0 || dropped !== 16'd0 || occ !== 4'd0) begin
      errors++;
      $display("FAIL rst_mid: req %b busy %b dropped %0d occ %0d want 0/0/0/0", seq_req, busy, dropped, occ);
    end
    d0 = done_cnt;
    idle(2);
    rst_n = 1'b1;
    idle(12);
    checks++;
    if (done_cnt !== d0) begin
      errors++;
      $display("FAIL rst_no_done: got %0d pulses want 0", done_cnt - d0);
    end
  endtask

  task automatic test_timestamp();
    logic [63:0] first;
    pulse_trig(16'h0055);
    repeat (99) @(posedge clk);
    #2;
    trig = 1'b1;
    trig_info = 16'h0056;
    @(posedge clk);
    #2;
    trig = 1'b0;
    first = last_hdr;
    wait_done("ts_done");
    idle(3);
    checks++;
    if (first[31:0] !== 32'h0000_0055) begin
      errors++;
      $display("FAIL ts_first_header: got %h want 00000055", first[31:0]);
    end
    checks++;
    if (last_hdr[31:0] !== 32'h0001_0056) begin
      errors++;
      $display("FAIL ts_second_header: got %h want 00010056", last_hdr[31:0]);
    end
`ifdef RADIANT_SEQ_TIMESTAMP_EN
    checks++;
    if (last_hdr[63:32] - first[63:32] !== 32'd100) begin
      errors++;
      $display("FAIL ts_delta: got %0d want 100", last_hdr[63:32] - first[63:32]);
    end
`else
    checks++;
    if (first[63:32] !== 32'h0 || last_hdr[63:32] !== 32'h0) begin
      errors++;
      $display("FAIL ts_zero: got %h/%h want 0/0", first[63:32], last_hdr[63:32]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_run_low();
    test_full();
    test_drop_during_seq();
    test_done_with_dma();
    test_header_stall();
    test_reset_mid();
    test_timestamp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
